// File: rtl/ram_reader.sv
// ram_reader: streams RAM words 0..RAM_SIZE-1 through a 2-entry FIFO with a valid/ready handshake.
// Optional build macro RAM_READER_CHECKSUM_EN adds a running modulo-2^RAM_WIDTH checksum of transferred words.
module ram_reader #(
  parameter int RAM_WIDTH  = 8,
  parameter int RAM_SIZE   = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  finished,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  write_enable,
  input  logic [RAM_WIDTH-1:0]  ram_out,
  output logic [RAM_WIDTH-1:0]  dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [RAM_WIDTH-1:0]  checksum
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(RAM_SIZE - 1);

  state_t               state;
  logic [ADDR_WIDTH:0]  next_addr;
  logic                 in_flight;
  logic [RAM_WIDTH-1:0] fifo_mem [2];
  logic                 rd_ptr;
  logic                 wr_ptr;
  logic [1:0]           fifo_count;
  logic [2:0]           credit;
  logic                 pop;
  logic                 issue;
  logic                 last_pop;

  assign write_enable = 1'b0;
  assign dout_valid   = (fifo_count != 2'd0);
  assign dout         = fifo_mem[rd_ptr];
  assign pop          = dout_valid & dout_ready;

  // Buffered words plus the read still landing, minus the word leaving now,
  // must leave room for one more, so the 2-entry FIFO can never overflow.
  assign credit   = {1'b0, fifo_count} + {2'b00, in_flight} - {2'b00, pop};
  assign issue    = (state == READ) && (credit < 3'd2);
  assign last_pop = pop && (fifo_count == 2'd1) && !in_flight;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      next_addr   <= '0;
      address     <= '0;
      in_flight   <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
      finished    <= 1'b0;
    end else begin
      finished  <= 1'b0;
      in_flight <= issue;

      if (issue) begin
        address   <= next_addr[ADDR_WIDTH-1:0];
        next_addr <= next_addr + 1'b1;
      end

      // RAM data returns the cycle after the address was issued.
      if (in_flight) begin
        fifo_mem[wr_ptr] <= ram_out;
        wr_ptr           <= ~wr_ptr;
      end

      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end

      case ({in_flight, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase

      case (state)
        IDLE: begin
          if (start) begin
            state     <= READ;
            next_addr <= '0;
          end
        end
        READ: begin
          if (issue && (next_addr == LAST_ADDR)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_pop) begin
            state    <= DONE;
            finished <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef RAM_READER_CHECKSUM_EN
  logic [RAM_WIDTH-1:0] sum;

  // Cleared as a pass begins, then holds its final value through DONE and IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum <= '0;
    end else if ((state == IDLE) && start) begin
      sum <= '0;
    end else if (pop) begin
      sum <= sum + dout;
    end
  end

  assign checksum = sum;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_ram_reader.sv
// tb_ram_reader: table-driven passes over a RAM holding s[i]=i, plus hand-written reset sequences.
// Checksum expectations follow RAM_READER_CHECKSUM_EN.
module tb_ram_reader;

  logic       clk;
  logic       reset;
  logic       start;
  logic       finished;
  logic [7:0] address;
  logic       write_enable;
  logic [7:0] ram_out;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic [7:0] checksum;

`ifdef RAM_READER_CHECKSUM_EN
  localparam logic [7:0] EXP_SUM = 8'h80;
`else
  localparam logic [7:0] EXP_SUM = 8'h00;
`endif

  typedef struct {
    int duty;
    int stall_at;
    int stall_len;
    int restart_at;
    bit hold_start;
    int exp_words;
    int exp_fins;
  } vec_t;

  vec_t vecs [7];
  int   n_compared;
  int   n_mismatched;

  logic [7:0] ram_mem [256];

  ram_reader #(
    .RAM_WIDTH (8),
    .RAM_SIZE  (256),
    .ADDR_WIDTH(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .finished    (finished),
    .address     (address),
    .write_enable(write_enable),
    .ram_out     (ram_out),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .checksum    (checksum)
  );

  // Read data is presented in time for the clock edge after the address changes.
  assign ram_out = ram_mem[address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int         words;
    int         fins;
    int         cycles;
    int         stall_cnt;
    int         first_lat;
    bit         holding;
    logic [7:0] held;
    logic [7:0] prev_addr;
    logic [7:0] step_addr;
    words     = 0;
    fins      = 0;
    cycles    = 0;
    stall_cnt = 0;
    first_lat = -1;
    holding   = 1'b0;
    held      = '0;
    prev_addr = address;
    start     = 1'b1;
    while (fins == 0 && cycles < 3000) begin
      @(negedge clk);
      cycles++;
      start = v.hold_start || (v.restart_at >= 0 && words == v.restart_at);
      if (dout_valid && first_lat < 0) begin
        first_lat = cycles - 1;
        checkOutput("first_valid_latency_le3", 32'(first_lat <= 3), 1);
      end
      if (holding) begin
        checkOutput("stall_hold_dout", dout, held);
        checkOutput("stall_hold_valid", dout_valid, 1);
      end
      if (address != prev_addr) begin
        step_addr = prev_addr + 8'd1;
        checkOutput("address_step", address, step_addr);
        prev_addr = address;
      end
      if (finished) begin
        fins++;
        checkOutput("words_before_finished", words, v.exp_words);
        checkOutput("checksum_at_finished", checksum, EXP_SUM);
      end
      if (dout_valid && v.stall_at >= 0 && words == v.stall_at && stall_cnt < v.stall_len) begin
        dout_ready = 1'b0;
        stall_cnt++;
      end else if (v.duty >= 100) begin
        dout_ready = 1'b1;
      end else begin
        dout_ready = (int'($urandom_range(0, 99)) < v.duty);
      end
      if (dout_valid && dout_ready) begin
        checkOutput("word_value", dout, words & 255);
        words++;
      end
      holding = dout_valid && !dout_ready;
      held    = dout;
    end
    checkOutput("finished_count", fins, v.exp_fins);
    @(negedge clk);
    start = v.hold_start;
    checkOutput("finished_one_cycle", finished, 0);
    checkOutput("idle_after_done_valid", dout_valid, 0);
    checkOutput("word_count", words, v.exp_words);
    checkOutput("write_enable_low", write_enable, 0);
  endtask

  initial begin
    int words;
    n_compared   = 0;
    n_mismatched = 0;
    for (int i = 0; i < 256; i++) ram_mem[i] = 8'(i);

    //         duty stall_at len restart hold words fins
    vecs[0] = '{100, -1,  0, -1,  1'b0, 256, 1};
    vecs[1] = '{100, 10,  5, -1,  1'b0, 256, 1};
    vecs[2] = '{30,  -1,  0, -1,  1'b0, 256, 1};
    vecs[3] = '{100, -1,  0, 100, 1'b0, 256, 1};
    vecs[4] = '{60,  255, 3, -1,  1'b0, 256, 1};
    vecs[5] = '{100, -1,  0, -1,  1'b1, 256, 1};
    vecs[6] = '{100, -1,  0, -1,  1'b0, 256, 1};

    reset      = 1'b1;
    start      = 1'b0;
    dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_address", address, 0);
    checkOutput("reset_dout", dout, 0);
    checkOutput("reset_valid", dout_valid, 0);
    checkOutput("reset_finished", finished, 0);
    checkOutput("reset_checksum", checksum, 0);
    checkOutput("reset_write_enable", write_enable, 0);
    reset = 1'b0;
    @(negedge clk);

    // Reset wins over a simultaneous start.
    reset      = 1'b1;
    start      = 1'b1;
    dout_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("reset_start_prio_valid", dout_valid, 0);
      checkOutput("reset_start_prio_addr", address, 0);
    end

    for (int i = 0; i < 7; i++) begin
      $display("[TB] vector %0d", i);
      applyStimulus(vecs[i]);
    end

    // Reset at word 50, mid-pass.
    words      = 0;
    start      = 1'b1;
    dout_ready = 1'b1;
    for (int c = 0; c < 500 && words < 50; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (dout_valid && dout_ready) words++;
    end
    checkOutput("reached_word_50", words, 50);
    @(negedge clk);
    checkOutput("dout_before_reset", dout, 50);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midpass_reset_valid", dout_valid, 0);
    checkOutput("midpass_reset_address", address, 0);
    checkOutput("midpass_reset_dout", dout, 0);
    checkOutput("midpass_reset_finished", finished, 0);
    checkOutput("midpass_reset_checksum", checksum, 0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("post_reset_idle_valid", dout_valid, 0);
      checkOutput("post_reset_idle_addr", address, 0);
    end
    applyStimulus(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/ram_reader.md
RAM_READER -- requirements
Module: ram_reader

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 8, the data word width in bits.
REQ-002 SHALL have parameter RAM_SIZE, default 256, the number of words to read, from address 0 to RAM_SIZE-1.
REQ-003 SHALL have parameter ADDR_WIDTH, default 8, the address width, with 2^ADDR_WIDTH >= RAM_SIZE.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: level, sampled only in IDLE, begins one read pass.
REQ-007 SHALL have port finished, output, 1 bit: one-cycle pulse when the pass completes.
REQ-008 SHALL have port address, output, ADDR_WIDTH bits: RAM read address, registered.
REQ-009 SHALL have port write_enable, output, 1 bit: RAM write enable, driven constant 0.
REQ-010 SHALL have port ram_out, input, RAM_WIDTH bits: RAM read data, valid exactly 1 cycle after the address.
REQ-011 SHALL have port dout, output, RAM_WIDTH bits: streamed word.
REQ-012 SHALL have port dout_valid, output, 1 bit: dout holds a valid word.
REQ-013 SHALL have port dout_ready, input, 1 bit: the consumer accepts the word; a transfer occurs when dout_valid and dout_ready are both high.
REQ-014 SHALL have port checksum, output, RAM_WIDTH bits: the running checksum (see Configuration).

Function
REQ-015 SHALL implement the states IDLE, READ, DRAIN and DONE.
- IDLE->READ on start=1.
- READ->DRAIN after the read of address RAM_SIZE-1 is issued.
- DRAIN->DONE when the last word is transferred.
- DONE->IDLE unconditionally after 1 cycle.
REQ-016 SHALL assert finished in the DONE cycle only.
REQ-017 SHALL issue reads in ascending order 0..RAM_SIZE-1, one address per issue, with no skipped or repeated address.
REQ-018 SHALL land each issued read into a 2-entry output FIFO one cycle after issue.
REQ-019 SHALL issue a read in a cycle only when (FIFO occupancy + in-flight reads - pop this cycle) < 2, so the FIFO never overflows.
REQ-020 SHALL sustain 1 word per cycle while dout_ready is held high.
REQ-021 SHALL raise the first dout_valid no later than 3 cycles after start is sampled.
REQ-022 SHALL hold dout and dout_valid stable while dout_valid=1 and dout_ready=0; words are never dropped or duplicated.
REQ-023 SHALL ignore start in READ, DRAIN and DONE; start held high in IDLE after DONE SHALL begin a new pass.
REQ-024 SHALL keep the address counter ADDR_WIDTH+1 bits wide internally, so RAM_SIZE=2^ADDR_WIDTH terminates without wrap aliasing.
REQ-025 SHALL hold address at its last issued value when no read is issued.

Reset
REQ-026 SHALL, on reset=1 at any clock edge including mid-pass, set state to IDLE, FIFO to empty, in-flight reads to 0, address to 0, dout to 0, dout_valid to 0, finished to 0 and checksum to 0.
REQ-027 SHALL discard any RAM data returning in the cycle after reset.
REQ-028 SHALL take priority over start when reset and start are asserted together.

Configuration
REQ-029 SHALL use macro RAM_READER_CHECKSUM_EN to select the checksum feature.
- Defined: checksum is cleared on the IDLE->READ transition and accumulates each transferred word by modulo-2^RAM_WIDTH addition; it holds its final value from DONE until the next pass starts.
- Undefined: checksum is driven constant 0 and the adder is absent; all other behaviour is identical.

Verification
REQ-030 SHALL cover: RAM holds s[i]=i, dout_ready=1, start pulsed -> dout carries 0,1,...,255 on consecutive cycles, finished pulses once, address never exceeds 255.
REQ-031 SHALL cover: dout_ready=0 for 5 cycles while dout=10 -> dout stays at 10 with valid high; the stream resumes at 11 with no loss; at most 2 reads are outstanding-plus-buffered.
REQ-032 SHALL cover: random dout_ready at 30% duty -> the received sequence equals 0..255 exactly and finished pulses after the last transfer.
REQ-033 SHALL cover: start pulsed again at word 100 -> ignored, exactly 256 words and one finished; start held high -> back-to-back passes.
REQ-034 SHALL cover: reset asserted at word 50 -> next cycle dout_valid=0, address=0, state IDLE, no stale word emitted; a new start gives a full pass beginning at word 0.
REQ-035 SHALL cover: with RAM_READER_CHECKSUM_EN and s[i]=i -> checksum=8'h80 at finished; without the macro -> checksum=0 throughout.
